cg_result_collector: RTL and testbench

- Downstream consumer of the clock-gated image-processing core.
- Takes the core's 16-beat signed 7-bit result burst (out_valid/out_data, one 4x4 tile per frame).
- Checks burst length and computes per-frame sum/min/max.
- Queues frame summaries in a 2-entry FIFO and emits them to the host-side stage over a valid/ready handshake.

---
 rtl/cg_result_collector_if.sv | 29 ++
 rtl/cg_result_collector.sv | 175 +++++++++++++++++
 tb/tb_cg_result_collector.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cg_result_collector_if.sv
// cg_result_collector_if: beat stream from the clock-gated image core plus the
// frame-summary stream towards the host-side stage, bundled for one link.
// The master side drives beats and out_ready; the slave (the collector) drives
// the summary fields and the sticky overflow flag.
interface cg_result_collector_if;
  logic              in_valid;
  logic        [6:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic       [10:0] out_sum;
  logic        [6:0] out_max;
  logic        [6:0] out_min;
  logic        [5:0] out_cnt;
  logic              out_err_short;
  logic              out_err_long;
  logic              overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_sum, out_max, out_min, out_cnt,
           out_err_short, out_err_long, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_sum, out_max, out_min, out_cnt,
           out_err_short, out_err_long, overflow
  );
endinterface

// File: rtl/cg_result_collector.sv
// cg_result_collector: collects one signed 7-bit result burst per frame,
// checks its length, builds sum/min/max and queues the summary in a small
// FIFO that drains over a valid/ready handshake.
// Optional macro RESULT_CG_EN: statistic and FIFO storage registers run on
// latch-based gated clocks; FSM, counters and pointers stay on clk.
module cg_result_collector #(
  parameter int FRAME_LEN = 16,
  parameter int DEPTH     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cg_en,
  cg_result_collector_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [5:0]  FRAME_LEN_C = 6'(FRAME_LEN);
  localparam logic [PW:0] DEPTH_C     = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef struct packed {
    logic signed [10:0] sum;
    logic signed [6:0]  maxVal;
    logic signed [6:0]  minVal;
    logic        [5:0]  cnt;
    logic               errShort;
    logic               errLong;
  } entry_t;

  state_t             state_q;
  logic        [5:0]  cnt_q;
  logic signed [10:0] sum_q, sum_d;
  logic signed [6:0]  max_q, max_d;
  logic signed [6:0]  min_q, min_d;
  entry_t             mem_q [DEPTH];
  logic        [PW-1:0] wrPtr_q, rdPtr_q;
  logic        [PW:0]   count_q, count_d;
  logic               overflow_q;

  logic signed [6:0]  inData;
  logic signed [10:0] dataExt;
  logic               startBeat, statBeat, statWe;
  logic               push, pop, full, fifoWe, drop, outValid;
  logic               statClk, fifoClk;
  entry_t             newEntry, head;

  assign inData    = $signed(bus.in_data);
  assign dataExt   = {{4{inData[6]}}, inData};
  assign startBeat = (state_q == IDLE) && bus.in_valid;
  assign statBeat  = (state_q == COLLECT) && bus.in_valid && (cnt_q < FRAME_LEN_C);
  assign statWe    = startBeat || statBeat;
  assign push      = (state_q == COLLECT) && !bus.in_valid;
  assign outValid  = (count_q != '0);
  assign pop       = outValid && bus.out_ready;
  assign full      = (count_q == DEPTH_C);
  assign fifoWe    = push && (!full || pop);
  assign drop      = push && full && !pop;

`ifdef RESULT_CG_EN
  logic statEnLat, fifoEnLat;

  // Latch-based clock gates: enables are captured while clk is low so the gated clocks cannot glitch
  always_latch begin
    if (!clk) begin
      statEnLat = !cg_en || statWe;
      fifoEnLat = !cg_en || fifoWe;
    end
  end

  assign statClk = clk & statEnLat;
  assign fifoClk = clk & fifoEnLat;
`else
  logic unusedCgEn;
  assign unusedCgEn = cg_en;
  assign statClk    = clk;
  assign fifoClk    = clk;
`endif

  // Next statistics: the first beat of a frame seeds them, later counted beats accumulate
  always_comb begin
    sum_d = sum_q + dataExt;
    max_d = max_q;
    min_d = min_q;
    if (startBeat) begin
      sum_d = dataExt;
      max_d = inData;
      min_d = inData;
    end else begin
      if (inData > max_q) max_d = inData;
      if (inData < min_q) min_d = inData;
    end
  end

  // Frame FSM and saturating beat counter; a reset drops any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= COLLECT;
            cnt_q   <= 6'd1;
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Statistic registers only move on beats that contribute to the frame summary
  always_ff @(posedge statClk) begin
    if (statWe) begin
      sum_q <= sum_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  always_comb begin
    newEntry.sum      = sum_q;
    newEntry.maxVal   = max_q;
    newEntry.minVal   = min_q;
    newEntry.cnt      = cnt_q;
    newEntry.errShort = (cnt_q < FRAME_LEN_C);
    newEntry.errLong  = (cnt_q > FRAME_LEN_C);
  end

  // Summary storage is written on the closing edge unless the frame is dropped
  always_ff @(posedge fifoClk) begin
    if (fifoWe) mem_q[wrPtr_q] <= newEntry;
  end

  // Occupancy bookkeeping; a simultaneous pop frees the slot a full-FIFO push needs
  always_comb begin
    count_d = count_q;
    if (fifoWe && !pop)      count_d = count_q + 1'b1;
    else if (!fifoWe && pop) count_d = count_q - 1'b1;
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifoWe) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign head              = mem_q[rdPtr_q];
  assign bus.out_valid     = outValid;
  assign bus.out_sum       = outValid ? head.sum      : '0;
  assign bus.out_max       = outValid ? head.maxVal   : '0;
  assign bus.out_min       = outValid ? head.minVal   : '0;
  assign bus.out_cnt       = outValid ? head.cnt      : '0;
  assign bus.out_err_short = outValid && head.errShort;
  assign bus.out_err_long  = outValid && head.errLong;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_cg_result_collector.sv
// tb_cg_result_collector: directed frames plus randomized bursts, compared
// every cycle against a queue-based frame-summary reference model.
module tb_cg_result_collector;

  localparam int FRAME_LEN = 16;
  localparam int DEPTH     = 2;

  logic clk = 1'b0;
  logic rst;
  logic cg_en;
  int   checks   = 0;
  int   failures = 0;
  bit   chkEn    = 1'b0;

  cg_result_collector_if bus();

  cg_result_collector #(.FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .cg_en(cg_en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int mx;
    int mn;
    int cnt;
    int es;
    int el;
  } summ_t;

  summ_t expQ[$];
  int    beats[$];
  bit    inFrame = 1'b0;
  bit    ovExp   = 1'b0;
  logic signed [6:0] burst [80];

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Summary of the collected frame straight from the rules: stats over the first FRAME_LEN beats
  function automatic summ_t summarize();
    summ_t s;
    int n = beats.size();
    int lim = (n < FRAME_LEN) ? n : FRAME_LEN;
    s.sum = 0;
    s.mx  = -1000;
    s.mn  = 1000;
    for (int i = 0; i < lim; i++) begin
      s.sum += beats[i];
      if (beats[i] > s.mx) s.mx = beats[i];
      if (beats[i] < s.mn) s.mn = beats[i];
    end
    s.cnt = (n > 63) ? 63 : n;
    s.es  = (n < FRAME_LEN) ? 1 : 0;
    s.el  = (n > FRAME_LEN) ? 1 : 0;
    return s;
  endfunction

  // Reference model: frames as beat lists, the FIFO as a bounded queue
  always @(posedge clk) begin
    summ_t s;
    if (rst) begin
      expQ.delete();
      beats.delete();
      inFrame = 1'b0;
      ovExp   = 1'b0;
    end else begin
      if (expQ.size() > 0 && bus.out_ready) void'(expQ.pop_front());
      if (inFrame && !bus.in_valid) begin
        s = summarize();
        if (expQ.size() < DEPTH) expQ.push_back(s);
        else ovExp = 1'b1;
        beats.delete();
        inFrame = 1'b0;
      end
      if (bus.in_valid) begin
        if (!inFrame) begin
          beats.delete();
          inFrame = 1'b1;
        end
        beats.push_back(int'($signed(bus.in_data)));
      end
    end
  end

  // Cycle-by-cycle comparison of the handshake and head fields against the model
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("out_valid", bus.out_valid, expQ.size() != 0);
      checkOutput("overflow", bus.overflow, ovExp);
      if (expQ.size() != 0) begin
        checkOutput("sum", $signed(bus.out_sum), expQ[0].sum);
        checkOutput("max", $signed(bus.out_max), expQ[0].mx);
        checkOutput("min", $signed(bus.out_min), expQ[0].mn);
        checkOutput("cnt", bus.out_cnt, expQ[0].cnt);
        checkOutput("err_short", bus.out_err_short, expQ[0].es);
        checkOutput("err_long", bus.out_err_long, expQ[0].el);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [6:0] d, input logic rdy);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = v ? d : 7'($urandom);
    bus.out_ready = rdy;
    cg_en         = 1'($urandom);
  endtask

  // rdyMode: 0/1 fixed out_ready, 2 random per cycle
  task automatic sendBurst(input int n, input int rdyMode, input int gaps);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, burst[i], (rdyMode == 2) ? 1'($urandom) : 1'(rdyMode));
    for (int g = 0; g < gaps; g++)
      applyStimulus(1'b0, 7'd0, (rdyMode == 2) ? 1'($urandom) : 1'(rdyMode));
  endtask

  task automatic fillBurst(input int n, input int val);
    for (int i = 0; i < n; i++) burst[i] = 7'(val);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkHead(input int s, input int mx, input int mn, input int c,
                           input int es, input int el);
    checkOutput("dir_valid", bus.out_valid, 1'b1);
    checkOutput("dir_sum", $signed(bus.out_sum), s);
    checkOutput("dir_max", $signed(bus.out_max), mx);
    checkOutput("dir_min", $signed(bus.out_min), mn);
    checkOutput("dir_cnt", bus.out_cnt, c);
    checkOutput("dir_err_short", bus.out_err_short, es);
    checkOutput("dir_err_long", bus.out_err_long, el);
  endtask

  // Closing edge follows the gap cycle; the summary is visible one cycle later
  task automatic frameAndCheck(input int n, input int s, input int mx, input int mn,
                               input int es, input int el);
    sendBurst(n, 1, 1);
    @(posedge clk);
    @(negedge clk);
    checkHead(s, mx, mn, (n > 63) ? 63 : n, es, el);
  endtask

  initial begin
    rst           = 1'b1;
    cg_en         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 7'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    chkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", bus.out_valid, 1'b0);
    checkOutput("rst_sum", bus.out_sum, 0);
    checkOutput("rst_cnt", bus.out_cnt, 0);
    checkOutput("rst_overflow", bus.overflow, 1'b0);

    for (int i = 0; i < 16; i++) burst[i] = 7'(i);
    frameAndCheck(16, 120, 15, 0, 0, 0);
    fillBurst(16, -64);
    frameAndCheck(16, -1024, -64, -64, 0, 0);
    fillBurst(16, 63);
    frameAndCheck(16, 1008, 63, 63, 0, 0);
    fillBurst(10, 5);
    frameAndCheck(10, 50, 5, 5, 1, 0);
    fillBurst(16, 1);
    for (int i = 16; i < 20; i++) burst[i] = 7'd63;
    frameAndCheck(20, 16, 1, 1, 0, 1);
    applyStimulus(1'b0, 7'd0, 1'b1);
    applyStimulus(1'b0, 7'd0, 1'b1);

    // Backpressure: three frames, the third is dropped
    for (int f = 1; f <= 3; f++) begin
      fillBurst(16, f);
      sendBurst(16, 0, 1);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_overflow", bus.overflow, 1'b1);
    checkOutput("bp_head0", $signed(bus.out_sum), 16);
    applyStimulus(1'b0, 7'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_head1", $signed(bus.out_sum), 32);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_drained", bus.out_valid, 1'b0);

    // Full FIFO with a pop on the closing edge of a new frame
    resetDut();
    fillBurst(16, 4);
    sendBurst(16, 0, 1);
    fillBurst(16, 5);
    sendBurst(16, 0, 1);
    fillBurst(16, 6);
    sendBurst(16, 0, 0);
    applyStimulus(1'b0, 7'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pp_overflow", bus.overflow, 1'b0);
    checkOutput("pp_head", $signed(bus.out_sum), 80);
    applyStimulus(1'b0, 7'd0, 1'b1);
    applyStimulus(1'b0, 7'd0, 1'b1);
    applyStimulus(1'b0, 7'd0, 1'b1);

    // Reset in the middle of a burst
    fillBurst(16, 9);
    sendBurst(8, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_sum", bus.out_sum, 0);
    fillBurst(16, -3);
    frameAndCheck(16, -48, -3, -3, 0, 0);

    // Randomized frames, gaps, backpressure and occasional resets
    for (int f = 0; f < 150; f++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 70) : $urandom_range(1, 20);
      for (int i = 0; i < n; i++) burst[i] = 7'($urandom);
      if ($urandom_range(0, 24) == 0) resetDut();
      sendBurst(n, 2, $urandom_range(1, 3));
    end
    repeat (6) applyStimulus(1'b0, 7'd0, 1'b1);
    @(negedge clk);
    checkOutput("final_empty", bus.out_valid, 1'b0);

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
